// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle ALU stage. A start request in IDLE latches A, B and opCode.
//   The stage then runs one operation and presents an 8-bit registered
//   result with a one-cycle done pulse.
//   - Logic, add, subtract and compare ops take one CALC cycle.
//   - Multiply (shift-add) and divide (restoring) take four CALC cycles.
//
// Ports
//   in_clk    : system clock, all state changes on the rising edge
//   reset     : synchronous, active-high; aborts any operation
//   A, B      : 4-bit unsigned operands
//   opCode    : 3-bit operation select
//   start     : operation request, sampled only while IDLE
//   result    : 8-bit registered result, written only on entry to DONE
//   busy      : high whenever the stage is not IDLE
//   done      : one-cycle pulse while in DONE
//   error     : divide-by-zero flag, sticky until the next accepted start
//   dbg_state : current FSM state, for observation only
//
// Handshake: start behaves as a valid, and !busy as the matching ready.
//   A request transfers on a rising edge where start && !busy.
//   Requests made while busy are dropped, not queued.
//   Completion is the single-cycle done pulse; result is valid from that
//   cycle until the next completion.
module alu_sequencer (
  input  logic       in_clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [2:0] opCode,
  input  logic       start,
  output logic [7:0] result,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  state_t     state;
  logic [3:0] a_q, b_q;
  logic [2:0] op_q;
  logic [1:0] cnt;
  // multiply datapath
  logic [7:0] acc;
  logic [7:0] mcand;
  logic [3:0] mplier;
  // divide datapath; quo starts as the dividend and fills with quotient bits
  logic [3:0] rem;
  logic [3:0] quo;

  logic [4:0] sum5, diff5;
  logic [7:0] single_res;
  logic [7:0] acc_nx;
  logic [4:0] rem_sh;
  logic [3:0] rem_nx, quo_nx;
  logic       div_zero, iterative;

  assign dbg_state = state;

  always_comb begin
    sum5       = {1'b0, a_q} + {1'b0, b_q};
    diff5      = {1'b0, a_q} - {1'b0, b_q};
    single_res = 8'h00;
    case (op_q)
      OP_ADD:  single_res = {3'b000, sum5};
      OP_SUB:  single_res = {{3{diff5[4]}}, diff5};
      OP_AND:  single_res = {4'h0, a_q & b_q};
      OP_OR:   single_res = {4'h0, a_q | b_q};
      OP_XOR:  single_res = {4'h0, a_q ^ b_q};
      OP_CMP:  single_res = {6'b000000, (a_q > b_q), (a_q == b_q)};
      default: single_res = 8'hFF;  // only the divide-by-zero case reaches here
    endcase
  end

  always_comb begin
    acc_nx = mplier[0] ? (acc + mcand) : acc;
    // Restoring step. The remainder stays below B, so both the shifted
    // value minus B and the shifted value kept as-is fit in 4 bits.
    rem_sh = {rem, quo[3]};
    if (rem_sh >= {1'b0, b_q}) begin
      rem_nx = rem_sh[3:0] - b_q;
      quo_nx = {quo[2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[3:0];
      quo_nx = {quo[2:0], 1'b0};
    end
  end

  assign div_zero  = (op_q == OP_DIV) && (b_q == 4'h0);
  assign iterative = (op_q == OP_MUL) || ((op_q == OP_DIV) && !div_zero);

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state  <= S_IDLE;
      result <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      a_q    <= 4'h0;
      b_q    <= 4'h0;
      op_q   <= 3'b000;
      cnt    <= 2'd0;
      acc    <= 8'h00;
      mcand  <= 8'h00;
      mplier <= 4'h0;
      rem    <= 4'h0;
      quo    <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= S_CALC;
            busy   <= 1'b1;
            error  <= 1'b0;
            a_q    <= A;
            b_q    <= B;
            op_q   <= opCode;
            cnt    <= 2'd3;
            acc    <= 8'h00;
            mcand  <= {4'h0, A};
            mplier <= B;
            rem    <= 4'h0;
            quo    <= A;
          end
        end
        S_CALC: begin
          if (!iterative) begin
            state  <= S_DONE;
            done   <= 1'b1;
            result <= single_res;
            error  <= div_zero;
          end else begin
            // The iteration on the edge where cnt is 0 is folded straight
            // into result, so partial values never reach the output.
            acc    <= acc_nx;
            mcand  <= {mcand[6:0], 1'b0};
            mplier <= {1'b0, mplier[3:1]};
            rem    <= rem_nx;
            quo    <= quo_nx;
            cnt    <= cnt - 2'd1;
            if (cnt == 2'd0) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= (op_q == OP_MUL) ? acc_nx : {rem_nx, quo_nx};
              error  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
